// File: rtl/spi_rom_responder.sv
// SPI mode-0 serial ROM responder (READ 0x03, JEDEC ID 0x9F, STATUS 0x05).
// All SPI pins are resynchronized into clk; edges are detected on the
// synchronized copies, so sclk must run at clk/8 or slower.
// Ports:
//   clk, rst_n              system clock, async active-low reset
//   spi_cs_n/sclk/di        SPI initiator inputs (asynchronous to clk)
//   spi_do, spi_do_oe       responder data and pad output enable
//   mem_rd, mem_addr        one-cycle read strobe and byte address
//   mem_rdata               read data, valid one clk after mem_rd
//   busy                    inverse of synchronized cs_n
module spi_rom_responder #(
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
  parameter logic [7:0]  STATUS_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_cs_n,
  input  logic        spi_sclk,
  input  logic        spi_di,
  output logic        spi_do,
  output logic        spi_do_oe,
  output logic        mem_rd,
  output logic [23:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_DATA   = 3'd3,
    S_ID     = 3'd4,
    S_STAT   = 3'd5,
    S_IGNORE = 3'd6
  } state_t;

  // Synchronizers and edge-detect history
  logic       cs_meta, cs_sync, cs_prev;
  logic       sclk_meta, sclk_sync, sclk_prev;
  logic       di_meta, di_sync;
  logic [1:0] fill_q;
  logic       armed_q;

  logic cs_rise, cs_fall, sclk_rise, sclk_fall;

  // FSM and datapath registers
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [IDX_W-1:0]    id_idx_q, id_idx_d;
  logic                rd_pend_q, rd_pend_d;
  logic [BYTE_W-1:0]   pbuf_q, pbuf_d;
  logic                do_d, oe_d, mem_rd_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [BYTE_W-1:0]   load_byte;
  logic [BYTE_W-1:0]   cmd_byte;
  logic [ADDR_W-1:0]   addr_shift;

  // 2-flop synchronizers; busy tracks the synchronized cs_n in lockstep.
  // fill_q marks when cs_sync holds a real post-reset sample, so a cs_n that
  // was already low across reset is not mistaken for a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      cs_prev   <= 1'b1;
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
      di_meta   <= 1'b0;
      di_sync   <= 1'b0;
      fill_q    <= '0;
      armed_q   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cs_meta   <= spi_cs_n;
      cs_sync   <= cs_meta;
      cs_prev   <= cs_sync;
      busy      <= ~cs_meta;
      sclk_meta <= spi_sclk;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      di_meta   <= spi_di;
      di_sync   <= di_meta;
      fill_q    <= {fill_q[0], 1'b1};
      if (fill_q[1] && cs_sync) armed_q <= 1'b1;
    end
  end

  assign cs_rise   = cs_sync & ~cs_prev;
  assign cs_fall   = ~cs_sync & cs_prev & armed_q;
  assign sclk_rise = sclk_sync & ~sclk_prev;
  assign sclk_fall = ~sclk_sync & sclk_prev;

  // State and datapath register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      id_idx_q  <= '0;
      rd_pend_q <= 1'b0;
      pbuf_q    <= '0;
      spi_do    <= 1'b0;
      spi_do_oe <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      id_idx_q  <= id_idx_d;
      rd_pend_q <= rd_pend_d;
      pbuf_q    <= pbuf_d;
      spi_do    <= do_d;
      spi_do_oe <= oe_d;
      mem_rd    <= mem_rd_d;
      mem_addr  <= mem_addr_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    id_idx_d   = id_idx_q;
    do_d       = spi_do;
    oe_d       = spi_do_oe;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr;
    rd_pend_d  = mem_rd;
    pbuf_d     = rd_pend_q ? mem_rdata : pbuf_q;
    cmd_byte   = {shift_q[BYTE_W-2:0], di_sync};
    addr_shift = {addr_q[ADDR_W-2:0], di_sync};

    // Byte presented at the next byte boundary in the streaming states
    load_byte = STATUS_BYTE;
    if (state_q == S_DATA) begin
      load_byte = pbuf_q;
    end else if (state_q == S_ID) begin
      case (id_idx_q)
        2'd0:    load_byte = JEDEC_ID[23:16];
        2'd1:    load_byte = JEDEC_ID[15:8];
        default: load_byte = JEDEC_ID[7:0];
      endcase
    end

    if (cs_rise) begin
      // Deselect wins over any coincident sclk edge; partial byte is dropped
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
      id_idx_d  = '0;
      do_d      = 1'b0;
      oe_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            state_d   = S_CMD;
            bit_cnt_d = '0;
            shift_d   = '0;
            id_idx_d  = '0;
            do_d      = 1'b0;
            oe_d      = 1'b0;
          end
        end

        S_CMD: begin
          if (sclk_rise) begin
            shift_d = cmd_byte;
            if (bit_cnt_q == CNT_W'(7)) begin
              bit_cnt_d = '0;
              shift_d   = '0;
              case (cmd_byte)
                8'h03:   state_d = S_ADDR;
                8'h9F:   state_d = S_ID;
                8'h05:   state_d = S_STAT;
                default: state_d = S_IGNORE;
              endcase
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end

        S_ADDR: begin
          if (sclk_rise) begin
            addr_d = addr_shift;
            if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
              bit_cnt_d  = '0;
              mem_rd_d   = 1'b1;
              mem_addr_d = addr_shift;
              state_d    = S_DATA;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end

        S_DATA, S_ID, S_STAT: begin
          if (sclk_fall) begin
            oe_d = 1'b1;
            if (bit_cnt_q == '0) begin
              do_d    = load_byte[BYTE_W-1];
              shift_d = {load_byte[BYTE_W-2:0], 1'b0};
            end else begin
              do_d    = shift_q[BYTE_W-1];
              shift_d = {shift_q[BYTE_W-2:0], 1'b0};
            end
          end else if (sclk_rise) begin
            if (bit_cnt_q == CNT_W'(7)) begin
              bit_cnt_d = '0;
              if (state_q == S_DATA) begin
                // Prefetch the next byte while bit 0 of this one is sampled
                addr_d     = addr_q + ADDR_W'(1);
                mem_addr_d = addr_q + ADDR_W'(1);
                mem_rd_d   = 1'b1;
              end else if (state_q == S_ID) begin
                id_idx_d = (id_idx_q == IDX_W'(2)) ? '0 : id_idx_q + IDX_W'(1);
              end
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end

        S_IGNORE: begin
          do_d = 1'b0;
          oe_d = 1'b0;
        end

        default: begin
          state_d = S_IDLE;
          do_d    = 1'b0;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_rom_responder.sv
// Directed bench for spi_rom_responder: an SPI initiator drives transactions,
// a behavioural ROM answers mem_rd, and a per-cycle monitor checks read
// addresses against an expected queue plus output-enable/data gating rules.
module tb_spi_rom_responder;

  localparam logic [23:0] JEDEC = 24'hEF4018;
  localparam logic [7:0]  STAT  = 8'h00;
  localparam int          HALF  = 50;

  logic        clk;
  logic        rst_n;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_di;
  logic        spi_do;
  logic        spi_do_oe;
  logic        mem_rd;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        busy;

  int n_vec = 0;
  int n_mis = 0;
  logic [23:0] exp_rd_q[$];
  logic        oe_allowed = 1'b0;
  logic [7:0]  rx_buf [4];

  spi_rom_responder #(.JEDEC_ID(JEDEC), .STATUS_BYTE(STAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_cs_n  (spi_cs_n),
    .spi_sclk  (spi_sclk),
    .spi_di    (spi_di),
    .spi_do    (spi_do),
    .spi_do_oe (spi_do_oe),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: a few pinned locations, a formula elsewhere
  function automatic logic [7:0] mem_val(input logic [23:0] a);
    case (a)
      24'h000010: return 8'hA5;
      24'h000011: return 8'h3C;
      24'h000020: return 8'h96;
      24'h000040: return 8'hD2;
      24'hFFFFFF: return 8'hC3;
      24'h000000: return 8'h7E;
      default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h55;
    endcase
  endfunction

  always @(posedge clk) if (mem_rd) mem_rdata <= mem_val(mem_addr);

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Per-cycle monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd) begin
        if (exp_rd_q.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL unexpected_mem_rd: got addr 0x%0h expected no read at %0t", mem_addr, $time);
        end else begin
          check("mem_rd_addr", 32'(mem_addr), 32'(exp_rd_q.pop_front()));
        end
      end
      check("do_gated", 32'(spi_do & ~spi_do_oe), 32'd0);
      if (!oe_allowed) check("oe_quiet", 32'(spi_do_oe), 32'd0);
    end
  end

  // Expected byte i of a non-read command stream
  function automatic logic [7:0] cmd_model(input logic [7:0] cmd, input int i);
    case (cmd)
      8'h9F:   return 8'(JEDEC >> (8 * (2 - (i % 3))));
      8'h05:   return STAT;
      default: return 8'h00;
    endcase
  endfunction

  // Mode 0: drive di while sclk low, both sides sample on the rise
  task automatic spi_bits(input logic [7:0] tx, input int n, input logic chk_oe,
                          output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      spi_di = tx[7-i];
      #(HALF);
      spi_sclk = 1'b1;
      rx[7-i] = spi_do;
      if (chk_oe) check("oe_data", 32'(spi_do_oe), 32'd1);
      #(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    #(HALF);
    check("busy_open", 32'(busy), 32'd1);
  endtask

  task automatic cs_end();
    #(HALF);
    spi_cs_n = 1'b1;
    #(HALF);
    check("busy_closed", 32'(busy), 32'd0);
    oe_allowed = 1'b0;
    check("rd_outstanding", 32'(exp_rd_q.size()), 32'd0);
    exp_rd_q.delete();
    #(HALF);
  endtask

  // READ of nbytes; a prefetch follows the last bit of every byte
  task automatic do_read(input logic [23:0] a, input int nbytes);
    logic [7:0] rx;
    exp_rd_q.push_back(a);
    for (int i = 1; i <= nbytes; i++) exp_rd_q.push_back(a + 24'(i));
    cs_begin();
    spi_bits(8'h03, 8, 1'b0, rx);
    spi_bits(a[23:16], 8, 1'b0, rx);
    spi_bits(a[15:8], 8, 1'b0, rx);
    spi_bits(a[7:0], 8, 1'b0, rx);
    oe_allowed = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      spi_bits(8'h00, 8, 1'b1, rx);
      rx_buf[i] = rx;
      check("read_byte", 32'(rx), 32'(mem_val(a + 24'(i))));
    end
    cs_end();
  endtask

  task automatic do_cmd(input logic [7:0] cmd, input int nbytes);
    logic [7:0] rx;
    logic       streams;
    streams = (cmd == 8'h9F) || (cmd == 8'h05);
    cs_begin();
    spi_bits(cmd, 8, 1'b0, rx);
    oe_allowed = streams;
    for (int i = 0; i < nbytes; i++) begin
      spi_bits(8'h00, 8, streams, rx);
      rx_buf[i] = rx;
      check("cmd_byte", 32'(rx), 32'(cmd_model(cmd, i)));
    end
    cs_end();
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] ref_b;
    rst_n    = 1'b0;
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    spi_di   = 1'b0;

    #23;
    check("rst_do",    32'(spi_do),    32'd0);
    check("rst_oe",    32'(spi_do_oe), 32'd0);
    check("rst_rd",    32'(mem_rd),    32'd0);
    check("rst_addr",  32'(mem_addr),  32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    #10 rst_n = 1'b1;
    #(2*HALF);

    // sclk activity with cs_n high must do nothing
    spi_bits(8'h03, 8, 1'b0, rx);
    spi_bits(8'h9F, 8, 1'b0, rx);
    check("idle_busy", 32'(busy), 32'd0);
    #(HALF);

    do_read(24'h000010, 2);
    check("read10_b0", 32'(rx_buf[0]), 32'hA5);
    check("read10_b1", 32'(rx_buf[1]), 32'h3C);

    do_read(24'hFFFFFF, 2);
    check("wrap_b0", 32'(rx_buf[0]), 32'hC3);
    check("wrap_b1", 32'(rx_buf[1]), 32'h7E);

    do_cmd(8'h9F, 4);
    check("id_b0", 32'(rx_buf[0]), 32'hEF);
    check("id_b1", 32'(rx_buf[1]), 32'h40);
    check("id_b2", 32'(rx_buf[2]), 32'h18);
    check("id_b3", 32'(rx_buf[3]), 32'hEF);

    do_cmd(8'h05, 1);
    check("stat_b0", 32'(rx_buf[0]), 32'h00);

    do_cmd(8'hAB, 2);
    check("ign_b0", 32'(rx_buf[0]), 32'h00);
    check("ign_b1", 32'(rx_buf[1]), 32'h00);

    // READ aborted after 4 data bits, then a fresh READ
    exp_rd_q.push_back(24'h000040);
    cs_begin();
    spi_bits(8'h03, 8, 1'b0, rx);
    spi_bits(8'h00, 8, 1'b0, rx);
    spi_bits(8'h00, 8, 1'b0, rx);
    spi_bits(8'h40, 8, 1'b0, rx);
    oe_allowed = 1'b1;
    spi_bits(8'h00, 4, 1'b1, rx);
    ref_b = mem_val(24'h000040);
    check("abort_bits", 32'(rx[7:4]), 32'(ref_b[7:4]));
    check("abort_lit", 32'(rx[7:4]), 32'hD);
    cs_end();
    do_read(24'h000020, 1);
    check("after_abort", 32'(rx_buf[0]), 32'h96);

    // Reset during the address phase with cs_n held low
    cs_begin();
    spi_bits(8'h03, 8, 1'b0, rx);
    spi_bits(8'h12, 8, 1'b0, rx);
    rst_n = 1'b0;
    #1;
    check("mid_rst_do",   32'(spi_do),    32'd0);
    check("mid_rst_oe",   32'(spi_do_oe), 32'd0);
    check("mid_rst_rd",   32'(mem_rd),    32'd0);
    check("mid_rst_addr", 32'(mem_addr),  32'd0);
    check("mid_rst_busy", 32'(busy),      32'd0);
    #19 rst_n = 1'b1;
    #(HALF);
    spi_bits(8'h34, 8, 1'b0, rx);
    spi_bits(8'h56, 8, 1'b0, rx);
    spi_bits(8'h00, 8, 1'b0, rx);
    check("post_rst_b0", 32'(rx), 32'h00);
    spi_bits(8'h00, 8, 1'b0, rx);
    check("post_rst_b1", 32'(rx), 32'h00);
    check("post_rst_oe", 32'(spi_do_oe), 32'd0);
    cs_end();
    do_read(24'h000020, 1);
    check("post_rst_read", 32'(rx_buf[0]), 32'h96);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
